// File: rtl/bloom_pkg.sv
// Shared Bloom filter definitions: aging FSM encoding, slot layout and the slot-shift helper.
// The query/update blocks use the same slot layout, so the shift lives here rather than in the engine.
package bloom_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_ACK  = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_WR_REQ  = 3'd4,
      ST_WR_ACK  = 3'd5
   } sweepState_t;

   localparam int SLOT_WIDTH_DEFAULT = 9;

   // Widest word the shift helper handles; callers size-cast the result back to their word width.
   localparam int SHIFT_MAX_WIDTH = 64;

   // Ages a word by one slot: every slot moves one position toward the MSB end,
   // the oldest (top) slot falls off and the newest (bottom) slot becomes zero.
   function automatic logic [SHIFT_MAX_WIDTH-1:0] ageShift(
      input logic [SHIFT_MAX_WIDTH-1:0] word,
      input int                         slotWidth
   );
      return word << slotWidth;
   endfunction

endpackage

// File: rtl/bloom_sweep_timer.sv
// Free-running sweep interval timer: emits a one-cycle start pulse every i_interval cycles
// while enabled. An interval of zero parks the timer.
module bloom_sweep_timer #(
   parameter int TIMER_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_enable,
   input  logic [TIMER_WIDTH-1:0] i_interval,
   output logic                   o_fire
);

   logic [TIMER_WIDTH-1:0] r_count;
   logic                   w_running;
   logic [TIMER_WIDTH-1:0] w_terminal;

   assign w_running  = i_enable && (i_interval != '0);
   assign w_terminal = i_interval - TIMER_WIDTH'(1);

   // Using >= keeps the timer from running away when software shrinks the interval mid-count.
   assign o_fire = w_running && (r_count >= w_terminal);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (o_fire) begin
         r_count <= '0;
      end else if (w_running) begin
         r_count <= r_count + TIMER_WIDTH'(1);
      end
   end

endmodule

// File: rtl/bloom_shift_engine.sv
// Background aging engine: sweeps an SRAM word range through arbiter port 1,
// reading each word, shifting its slots by one and writing it back.
module bloom_shift_engine
   import bloom_pkg::*;
#(
   parameter int SRAM_ADDR_WIDTH = 19,
   parameter int SRAM_DATA_WIDTH = 36,
   parameter int SLOT_WIDTH      = SLOT_WIDTH_DEFAULT,
   parameter int TIMER_WIDTH     = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [TIMER_WIDTH-1:0]     sweep_interval,
   input  logic [SRAM_ADDR_WIDTH-1:0] sweep_base,
   input  logic [SRAM_ADDR_WIDTH-1:0] sweep_last,
   input  logic                       sweep_trigger,
   output logic                       wr_1_req,
   output logic [SRAM_ADDR_WIDTH-1:0] wr_1_addr,
   output logic [SRAM_DATA_WIDTH-1:0] wr_1_data,
   input  logic                       wr_1_ack,
   output logic                       rd_1_req,
   output logic [SRAM_ADDR_WIDTH-1:0] rd_1_addr,
   input  logic [SRAM_DATA_WIDTH-1:0] rd_1_data,
   input  logic                       rd_1_ack,
   input  logic                       rd_1_vld,
   output logic                       busy,
   output logic                       sweep_done,
   output logic [15:0]                sweep_count,
   output logic [15:0]                overrun_count,
   output logic                       ack_err
);

   sweepState_t                r_state;
   logic [SRAM_ADDR_WIDTH-1:0] r_addr;
   logic [SRAM_ADDR_WIDTH-1:0] r_last;
   logic [SRAM_DATA_WIDTH-1:0] r_wrData;
   logic                       r_rdReq;
   logic                       r_wrReq;
   logic                       r_busy;
   logic                       r_done;
   logic [15:0]                r_sweepCount;
   logic [15:0]                r_overrunCount;
   logic                       r_ackErr;

   logic                       w_timerFire;
   logic                       w_start;
   logic [SRAM_DATA_WIDTH-1:0] w_shifted;

   bloom_sweep_timer #(
      .TIMER_WIDTH(TIMER_WIDTH)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_enable  (enable),
      .i_interval(sweep_interval),
      .o_fire    (w_timerFire)
   );

   // A timer fire and a software trigger in the same cycle merge into one start.
   assign w_start   = enable && (w_timerFire || sweep_trigger);
   assign w_shifted = SRAM_DATA_WIDTH'(ageShift(SHIFT_MAX_WIDTH'(rd_1_data), SLOT_WIDTH));

   // Requests are one-cycle pulses raised on entry to a *_REQ state; if the arbiter is not
   // ready on entry the state holds with req low and raises it once enable returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_addr         <= '0;
         r_last         <= '0;
         r_wrData       <= '0;
         r_rdReq        <= 1'b0;
         r_wrReq        <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_sweepCount   <= '0;
         r_overrunCount <= '0;
         r_ackErr       <= 1'b0;
      end else begin
         r_rdReq <= 1'b0;
         r_wrReq <= 1'b0;
         r_done  <= 1'b0;

         if (w_start && r_busy && (r_overrunCount != 16'hFFFF)) begin
            r_overrunCount <= r_overrunCount + 16'd1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_addr  <= sweep_base;
                  r_last  <= sweep_last;
                  r_busy  <= 1'b1;
                  r_rdReq <= 1'b1;
                  r_state <= ST_RD_REQ;
               end
            end

            ST_RD_REQ: begin
               if (r_rdReq) begin
                  r_state <= ST_RD_ACK;
               end else if (enable) begin
                  r_rdReq <= 1'b1;
               end
            end

            ST_RD_ACK: begin
               if (rd_1_ack) begin
                  r_state <= ST_RD_WAIT;
               end else begin
                  r_ackErr <= 1'b1;
                  r_rdReq  <= enable;
                  r_state  <= ST_RD_REQ;
               end
            end

            // Read latency is not bounded here; the arbiter guarantees the data eventually.
            ST_RD_WAIT: begin
               if (rd_1_vld) begin
                  r_wrData <= w_shifted;
                  r_wrReq  <= enable;
                  r_state  <= ST_WR_REQ;
               end
            end

            ST_WR_REQ: begin
               if (r_wrReq) begin
                  r_state <= ST_WR_ACK;
               end else if (enable) begin
                  r_wrReq <= 1'b1;
               end
            end

            ST_WR_ACK: begin
               if (wr_1_ack) begin
                  if (r_addr == r_last) begin
                     r_busy       <= 1'b0;
                     r_done       <= 1'b1;
                     r_sweepCount <= r_sweepCount + 16'd1;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_addr  <= r_addr + SRAM_ADDR_WIDTH'(1);
                     r_rdReq <= enable;
                     r_state <= ST_RD_REQ;
                  end
               end else begin
                  r_ackErr <= 1'b1;
                  r_wrReq  <= enable;
                  r_state  <= ST_WR_REQ;
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_1_req      = r_rdReq;
   assign rd_1_addr     = r_addr;
   assign wr_1_req      = r_wrReq;
   assign wr_1_addr     = r_addr;
   assign wr_1_data     = r_wrData;
   assign busy          = r_busy;
   assign sweep_done    = r_done;
   assign sweep_count   = r_sweepCount;
   assign overrun_count = r_overrunCount;
   assign ack_err       = r_ackErr;

endmodule

// File: tb/tb_bloom_shift_engine.sv
// Scoreboard bench for bloom_shift_engine: an arbiter/SRAM responder, a reference memory
// that predicts every read and write-back, and a monitor that checks each request in order.
module tb_bloom_shift_engine;

   localparam int AW       = 19;
   localparam int DW       = 36;
   localparam int TW       = 32;
   localparam int ADDR_MOD = 1 << AW;

   logic          clk            = 1'b0;
   logic          reset          = 1'b1;
   logic          enable         = 1'b0;
   logic [TW-1:0] sweep_interval = '0;
   logic [AW-1:0] sweep_base     = '0;
   logic [AW-1:0] sweep_last     = '0;
   logic          sweep_trigger  = 1'b0;
   logic          wr_1_req;
   logic [AW-1:0] wr_1_addr;
   logic [DW-1:0] wr_1_data;
   logic          wr_1_ack       = 1'b0;
   logic          rd_1_req;
   logic [AW-1:0] rd_1_addr;
   logic [DW-1:0] rd_1_data      = '0;
   logic          rd_1_ack       = 1'b0;
   logic          rd_1_vld       = 1'b0;
   logic          busy;
   logic          sweep_done;
   logic [15:0]   sweep_count;
   logic [15:0]   overrun_count;
   logic          ack_err;

   typedef struct {
      bit            isWr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } xact_t;

   xact_t         expQ[$];
   logic [DW-1:0] arbMem[int];
   logic [DW-1:0] refMem[int];
   bit            ackRdAt[int];
   bit            ackWrAt[int];
   logic [DW-1:0] vldAt[int];
   int            rdCycles[$];
   int            wrCycles[$];

   int vectors       = 0;
   int miscompares   = 0;
   int cyc           = 0;
   int doneSeen      = 0;
   int expSweeps     = 0;
   bit dropNextRdAck = 1'b0;
   bit randLatency   = 1'b0;

   bloom_shift_engine #(
      .SRAM_ADDR_WIDTH(AW),
      .SRAM_DATA_WIDTH(DW),
      .SLOT_WIDTH     (9),
      .TIMER_WIDTH    (TW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .sweep_interval(sweep_interval),
      .sweep_base    (sweep_base),
      .sweep_last    (sweep_last),
      .sweep_trigger (sweep_trigger),
      .wr_1_req      (wr_1_req),
      .wr_1_addr     (wr_1_addr),
      .wr_1_data     (wr_1_data),
      .wr_1_ack      (wr_1_ack),
      .rd_1_req      (rd_1_req),
      .rd_1_addr     (rd_1_addr),
      .rd_1_data     (rd_1_data),
      .rd_1_ack      (rd_1_ack),
      .rd_1_vld      (rd_1_vld)
      ,
      .busy          (busy),
      .sweep_done    (sweep_done),
      .sweep_count   (sweep_count),
      .overrun_count (overrun_count),
      .ack_err       (ack_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic matchReq(input bit isWr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      xact_t e;
      if (expQ.size() == 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL unexpected_req: got %s at addr 0x%0h, expected no request",
                  isWr ? "write" : "read", addr);
         return;
      end
      e = expQ.pop_front();
      checkOutput(isWr ? "wr_kind" : "rd_kind", 64'(isWr), 64'(e.isWr));
      checkOutput(isWr ? "wr_addr" : "rd_addr", 64'(addr), 64'(e.addr));
      if (isWr) checkOutput("wr_data", 64'(data), 64'(e.data));
   endtask

   // Monitor: every request the DUT presents is matched against the head of the scoreboard.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (sweep_done) doneSeen++;
            if (rd_1_req) begin
               rdCycles.push_back(cyc);
               matchReq(1'b0, rd_1_addr, '0);
            end
            if (wr_1_req) begin
               wrCycles.push_back(cyc);
               matchReq(1'b1, wr_1_addr, wr_1_data);
            end
         end
      end
   end

   // Arbiter + SRAM responder: acks one cycle after a request, read data after a latency.
   initial begin : responder
      int lat;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         rd_1_ack  = ackRdAt.exists(cyc);
         wr_1_ack  = ackWrAt.exists(cyc);
         rd_1_vld  = vldAt.exists(cyc);
         rd_1_data = rd_1_vld ? vldAt[cyc] : '0;
         if (ackRdAt.exists(cyc)) ackRdAt.delete(cyc);
         if (ackWrAt.exists(cyc)) ackWrAt.delete(cyc);
         if (vldAt.exists(cyc)) vldAt.delete(cyc);
         @(negedge clk);
         if (rd_1_req) begin
            if (dropNextRdAck) begin
               dropNextRdAck = 1'b0;
            end else begin
               lat = randLatency ? int'($urandom_range(8, 4)) : 4;
               ackRdAt[cyc + 1] = 1'b1;
               vldAt[cyc + lat] = arbMem.exists(int'(rd_1_addr)) ? arbMem[int'(rd_1_addr)] : '0;
            end
         end
         if (wr_1_req) begin
            ackWrAt[cyc + 1] = 1'b1;
            arbMem[int'(wr_1_addr)] = wr_1_data;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setWord(input int addr, input logic [DW-1:0] data);
      arbMem[addr] = data;
      refMem[addr] = data;
   endtask

   task automatic setRandomWord(input int addr);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      setWord(addr, r[DW-1:0]);
   endtask

   // Reference model: a sweep reads base..last (wrapping at the top of the address space)
   // and writes each word back multiplied by 2^9, truncated to the word width.
   task automatic pushSweep(input int base, input int last, input bit retryFirst);
      int          a;
      logic [63:0] w;
      xact_t       e;
      a = base;
      expSweeps++;
      forever begin
         w = refMem.exists(a) ? 64'(refMem[a]) : 64'd0;
         w = (w * 64'd512) % 64'h10_0000_0000;
         if (retryFirst) begin
            e = '{isWr: 1'b0, addr: AW'(a), data: '0};
            expQ.push_back(e);
            retryFirst = 1'b0;
         end
         e = '{isWr: 1'b0, addr: AW'(a), data: '0};
         expQ.push_back(e);
         e = '{isWr: 1'b1, addr: AW'(a), data: w[DW-1:0]};
         expQ.push_back(e);
         refMem[a] = w[DW-1:0];
         if (a == last) break;
         a = (a + 1) % ADDR_MOD;
      end
   endtask

   task automatic applyStimulus(input int base, input int last);
      sweep_base    = AW'(base);
      sweep_last    = AW'(last);
      sweep_trigger = 1'b1;
      tick(1);
      sweep_trigger = 1'b0;
   endtask

   task automatic waitSweeps(input int target, input int budget);
      int n;
      n = 0;
      while (doneSeen < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (doneSeen < target) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL sweep_timeout: got %0d sweeps done, expected %0d", doneSeen, target);
      end
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      tick(1);
   endtask

   task automatic waitReads(input int target, input int budget);
      int n;
      n = 0;
      while (rdCycles.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (rdCycles.size() < target) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL read_timeout: got %0d reads, expected %0d", rdCycles.size(), target);
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int base;
      int len;
      int wrBefore;

      reset = 1'b1;
      tick(3);
      @(negedge clk);
      checkOutput("rst_busy",    64'(busy),          64'd0);
      checkOutput("rst_done",    64'(sweep_done),    64'd0);
      checkOutput("rst_count",   64'(sweep_count),   64'd0);
      checkOutput("rst_overrun", 64'(overrun_count), 64'd0);
      checkOutput("rst_ack_err", 64'(ack_err),       64'd0);
      checkOutput("rst_rd_req",  64'(rd_1_req),      64'd0);
      checkOutput("rst_wr_req",  64'(wr_1_req),      64'd0);
      checkOutput("rst_wr_data", 64'(wr_1_data),     64'd0);
      tick(1);
      reset  = 1'b0;
      enable = 1'b1;
      tick(2);

      // Basic three-word sweep; base/last are changed right after the trigger to prove latching.
      $display("[TB] basic sweep 0x10..0x12");
      setWord(32'h10, 36'h1_2345_6789);
      setWord(32'h11, 36'hF_FFFF_FFFF);
      setRandomWord(32'h12);
      rdCycles.delete();
      wrCycles.delete();
      pushSweep(32'h10, 32'h12, 1'b0);
      applyStimulus(32'h10, 32'h12);
      sweep_base = AW'(32'h55);
      sweep_last = AW'(32'h56);
      waitSweeps(expSweeps, 200);
      checkOutput("basic_reads", 64'(rdCycles.size()), 64'd3);
      if (rdCycles.size() == 3 && wrCycles.size() == 3) begin
         checkOutput("basic_gap_1", 64'(rdCycles[1] - rdCycles[0]), 64'd7);
         checkOutput("basic_gap_2", 64'(rdCycles[2] - rdCycles[1]), 64'd7);
         checkOutput("basic_wr_lat", 64'(wrCycles[0] - rdCycles[0]), 64'd5);
      end
      // 9-bit slot shift: {data[26:0], 9'b0}
      checkOutput("shift_word_a", 64'(arbMem[32'h10]), 64'h6_8ACF_1200);
      checkOutput("shift_word_b", 64'(arbMem[32'h11]), 64'hF_FFFF_FE00);
      checkOutput("basic_count",  64'(sweep_count),    64'd1);
      checkOutput("basic_done",   64'(doneSeen),       64'd1);
      checkOutput("basic_busy",   64'(busy),           64'd0);

      $display("[TB] wrapping sweep 0x7FFFF..0x00001");
      setRandomWord(32'h7FFFF);
      setRandomWord(32'h0);
      setRandomWord(32'h1);
      pushSweep(32'h7FFFF, 32'h1, 1'b0);
      applyStimulus(32'h7FFFF, 32'h1);
      waitSweeps(expSweeps, 200);
      checkOutput("wrap_count", 64'(sweep_count), 64'(expSweeps));

      $display("[TB] trigger with enable low");
      enable = 1'b0;
      applyStimulus(32'h30, 32'h31);
      tick(30);
      checkOutput("disabled_busy",    64'(busy),          64'd0);
      checkOutput("disabled_count",   64'(sweep_count),   64'(expSweeps));
      checkOutput("disabled_overrun", 64'(overrun_count), 64'd0);
      enable = 1'b1;
      tick(2);

      $display("[TB] timer driven sweeps with overrun");
      setRandomWord(32'h20);
      pushSweep(32'h20, 32'h20, 1'b0);
      pushSweep(32'h20, 32'h20, 1'b0);
      pushSweep(32'h20, 32'h20, 1'b0);
      rdCycles.delete();
      sweep_base     = AW'(32'h20);
      sweep_last     = AW'(32'h20);
      sweep_interval = TW'(100);
      waitReads(1, 300);
      tick(1);
      sweep_trigger = 1'b1;
      tick(1);
      sweep_trigger = 1'b0;
      waitSweeps(expSweeps, 400);
      sweep_interval = '0;
      checkOutput("timer_overrun", 64'(overrun_count), 64'd1);
      checkOutput("timer_reads",   64'(rdCycles.size()), 64'd3);
      if (rdCycles.size() == 3) begin
         checkOutput("timer_period_1", 64'(rdCycles[1] - rdCycles[0]), 64'd100);
         checkOutput("timer_period_2", 64'(rdCycles[2] - rdCycles[1]), 64'd100);
      end

      $display("[TB] withheld read ack");
      setRandomWord(32'h40);
      setRandomWord(32'h41);
      checkOutput("ack_err_before", 64'(ack_err), 64'd0);
      dropNextRdAck = 1'b1;
      pushSweep(32'h40, 32'h41, 1'b1);
      applyStimulus(32'h40, 32'h41);
      waitSweeps(expSweeps, 200);
      checkOutput("ack_err_after", 64'(ack_err), 64'd1);

      $display("[TB] randomized sweeps");
      randLatency = 1'b1;
      for (int i = 0; i < 6; i++) begin
         base = int'($urandom_range(ADDR_MOD - 1, 0));
         if (i == 0) base = ADDR_MOD - 2;
         len = int'($urandom_range(4, 0));
         for (int k = 0; k <= len; k++) setRandomWord((base + k) % ADDR_MOD);
         pushSweep(base, (base + len) % ADDR_MOD, 1'b0);
         applyStimulus(base, (base + len) % ADDR_MOD);
         waitSweeps(expSweeps, 300);
      end
      checkOutput("random_count", 64'(sweep_count), 64'(expSweeps));
      randLatency = 1'b0;

      $display("[TB] reset while waiting for read data");
      setRandomWord(32'h60);
      pushSweep(32'h60, 32'h60, 1'b0);
      rdCycles.delete();
      applyStimulus(32'h60, 32'h60);
      waitReads(1, 50);
      wrBefore = wrCycles.size();
      tick(2);
      reset = 1'b1;
      tick(5);
      expQ.delete();
      expSweeps = 0;
      doneSeen  = 0;
      reset     = 1'b0;
      @(negedge clk);
      checkOutput("rst2_busy",    64'(busy),          64'd0);
      checkOutput("rst2_count",   64'(sweep_count),   64'd0);
      checkOutput("rst2_overrun", 64'(overrun_count), 64'd0);
      checkOutput("rst2_ack_err", 64'(ack_err),       64'd0);
      checkOutput("rst2_rd_addr", 64'(rd_1_addr),     64'd0);
      checkOutput("rst2_wr_req",  64'(wr_1_req),      64'd0);
      tick(20);
      checkOutput("rst2_no_write", 64'(wrCycles.size()), 64'(wrBefore));
      checkOutput("rst2_idle",     64'(busy),            64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
